// File: rtl/reg_rename_file.sv
// rtl/reg_rename_file.sv - architectural register file with per-register rename tags
// Commit writes bypass to the read ports when they retire the register's newest producer.
module reg_rename_file #(
   parameter int ROB_BIT = 4,
   parameter int REG_NUM = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rdy,
   input  logic               rob_rb_ena,
   input  logic [4:0]         id_rs1,
   input  logic [4:0]         id_rs2,
   output logic               id_rs1_busy,
   output logic               id_rs2_busy,
   output logic [ROB_BIT-1:0] id_rs1_tag,
   output logic [ROB_BIT-1:0] id_rs2_tag,
   output logic [31:0]        id_rs1_val,
   output logic [31:0]        id_rs2_val,
   input  logic               id_rn_ena,
   input  logic [4:0]         id_rn_rd,
   input  logic [ROB_BIT-1:0] id_rn_idx,
   input  logic               reg_wr_ena,
   input  logic [4:0]         reg_wr_rd,
   input  logic [31:0]        reg_wr_val,
   input  logic [ROB_BIT-1:0] reg_wr_idx
);

   typedef struct packed {
      logic [31:0]        val;
      logic               busy;
      logic [ROB_BIT-1:0] tag;
   } rd_t;

   logic [31:0]        val_q  [REG_NUM];
   logic               busy_q [REG_NUM];
   logic [ROB_BIT-1:0] tag_q  [REG_NUM];

   rd_t rd1, rd2;

   function automatic rd_t read_port(input logic [4:0] rs);
      rd_t r;
      r = '0;
      if (rs != 5'd0) begin
         if (reg_wr_ena && reg_wr_rd == rs && tag_q[rs] == reg_wr_idx) begin
            r.val = reg_wr_val;
         end else begin
            r.val  = val_q[rs];
            r.busy = busy_q[rs];
            r.tag  = tag_q[rs];
         end
      end
      return r;
   endfunction

   // Gate on rst so reads stay zero even if a bypassing commit arrives during reset.
   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (rst) begin
         rd1 = read_port(id_rs1);
         rd2 = read_port(id_rs2);
      end
   end

   assign id_rs1_val  = rd1.val;
   assign id_rs1_busy = rd1.busy;
   assign id_rs1_tag  = rd1.tag;
   assign id_rs2_val  = rd2.val;
   assign id_rs2_busy = rd2.busy;
   assign id_rs2_tag  = rd2.tag;

   // Entry 0 is only ever written by reset, which keeps x0 at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            val_q[i]  <= '0;
            busy_q[i] <= 1'b0;
            tag_q[i]  <= '0;
         end
      end else if (rdy) begin
         for (int i = 1; i < REG_NUM; i++) begin
            if (reg_wr_ena && reg_wr_rd == 5'(i)) begin
               val_q[i] <= reg_wr_val;
            end
            if (rob_rb_ena) begin
               busy_q[i] <= 1'b0;
               tag_q[i]  <= '0;
            end else if (id_rn_ena && id_rn_rd == 5'(i)) begin
               busy_q[i] <= 1'b1;
               tag_q[i]  <= id_rn_idx;
            end else if (reg_wr_ena && reg_wr_rd == 5'(i) && tag_q[i] == reg_wr_idx) begin
               busy_q[i] <= 1'b0;
               tag_q[i]  <= '0;
            end
         end
      end
   end

   rename_idx_nonzero: assert property (@(posedge clk) disable iff (!rst)
      (rdy && id_rn_ena && id_rn_rd != 5'd0 && !rob_rb_ena) |-> id_rn_idx != '0);

endmodule

// File: tb/tb_reg_rename_file.sv
// tb/tb_reg_rename_file.sv - directed bench for reg_rename_file
// A per-cycle model check runs beside hand-computed literal expectations.
module tb_reg_rename_file;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        rdy = 1'b1;
   logic        rob_rb_ena = 1'b0;
   logic [4:0]  id_rs1 = '0, id_rs2 = '0;
   logic        id_rs1_busy, id_rs2_busy;
   logic [3:0]  id_rs1_tag, id_rs2_tag;
   logic [31:0] id_rs1_val, id_rs2_val;
   logic        id_rn_ena = 1'b0;
   logic [4:0]  id_rn_rd = '0;
   logic [3:0]  id_rn_idx = '0;
   logic        reg_wr_ena = 1'b0;
   logic [4:0]  reg_wr_rd = '0;
   logic [31:0] reg_wr_val = '0;
   logic [3:0]  reg_wr_idx = '0;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_val  [32];
   logic        m_busy [32];
   logic [3:0]  m_tag  [32];

   reg_rename_file #(.ROB_BIT(4), .REG_NUM(32)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rob_rb_ena(rob_rb_ena),
      .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_busy(id_rs1_busy), .id_rs2_busy(id_rs2_busy),
      .id_rs1_tag(id_rs1_tag), .id_rs2_tag(id_rs2_tag),
      .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val),
      .id_rn_ena(id_rn_ena), .id_rn_rd(id_rn_rd), .id_rn_idx(id_rn_idx),
      .reg_wr_ena(reg_wr_ena), .reg_wr_rd(reg_wr_rd),
      .reg_wr_val(reg_wr_val), .reg_wr_idx(reg_wr_idx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m_val[i]  = '0;
         m_busy[i] = 1'b0;
         m_tag[i]  = '0;
      end
   endtask

   // Apply one cycle's rules in order: commit, rename, then rollback overrides both renames.
   task automatic model_step();
      if (rdy) begin
         if (reg_wr_ena && reg_wr_rd != 0) begin
            m_val[reg_wr_rd] = reg_wr_val;
            if (m_tag[reg_wr_rd] == reg_wr_idx) begin
               m_busy[reg_wr_rd] = 1'b0;
               m_tag[reg_wr_rd]  = '0;
            end
         end
         if (id_rn_ena && id_rn_rd != 0) begin
            m_busy[id_rn_rd] = 1'b1;
            m_tag[id_rn_rd]  = id_rn_idx;
         end
         if (rob_rb_ena) begin
            for (int i = 0; i < 32; i++) begin
               m_busy[i] = 1'b0;
               m_tag[i]  = '0;
            end
         end
      end
   endtask

   function automatic logic [36:0] exp_read(input logic [4:0] rs);
      if (!rst || rs == 0) return '0;
      if (reg_wr_ena && reg_wr_rd == rs && m_tag[rs] == reg_wr_idx)
         return {reg_wr_val, 1'b0, 4'd0};
      return {m_val[rs], m_busy[rs], m_tag[rs]};
   endfunction

   initial model_clear();
   always @(negedge rst) model_clear();
   always @(posedge clk) if (rst) model_step();

   always @(negedge clk) begin
      logic [36:0] e1, e2;
      e1 = exp_read(id_rs1);
      e2 = exp_read(id_rs2);
      chk("model rs1_val", id_rs1_val, e1[36:5]);
      chk("model rs1_busy", 32'(id_rs1_busy), 32'(e1[4]));
      chk("model rs1_tag", 32'(id_rs1_tag), 32'(e1[3:0]));
      chk("model rs2_val", id_rs2_val, e2[36:5]);
      chk("model rs2_busy", 32'(id_rs2_busy), 32'(e2[4]));
      chk("model rs2_tag", 32'(id_rs2_tag), 32'(e2[3:0]));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rob_rb_ena = 1'b0;
      id_rn_ena  = 1'b0;
      reg_wr_ena = 1'b0;
   endtask

   task automatic rename(input logic [4:0] rd, input logic [3:0] idx);
      id_rn_ena = 1'b1; id_rn_rd = rd; id_rn_idx = idx;
   endtask

   task automatic commit(input logic [4:0] rd, input logic [31:0] v, input logic [3:0] idx);
      reg_wr_ena = 1'b1; reg_wr_rd = rd; reg_wr_val = v; reg_wr_idx = idx;
   endtask

   task automatic lit1(input string n, input logic [31:0] v, input logic b, input logic [3:0] t);
      chk({n, " val"}, id_rs1_val, v);
      chk({n, " busy"}, 32'(id_rs1_busy), 32'(b));
      chk({n, " tag"}, 32'(id_rs1_tag), 32'(t));
   endtask

   initial begin
      id_rs1 = 5'd5;
      #2;
      lit1("reset x5", 32'h0, 1'b0, 4'd0);
      tick(); tick();
      rst = 1'b1;
      tick();

      rename(5'd3, 4'd2);
      tick(); idle(); id_rs1 = 5'd3;
      @(negedge clk); lit1("renamed x3", 32'h0, 1'b1, 4'd2);
      tick(); commit(5'd3, 32'hDEADBEEF, 4'd2);
      @(negedge clk); lit1("bypass x3", 32'hDEADBEEF, 1'b0, 4'd0);
      tick(); idle();
      @(negedge clk); lit1("stored x3", 32'hDEADBEEF, 1'b0, 4'd0);

      tick(); rename(5'd7, 4'd3);
      tick(); rename(5'd7, 4'd5);
      tick(); idle(); commit(5'd7, 32'h11, 4'd3);
      tick(); idle(); id_rs1 = 5'd7;
      @(negedge clk); lit1("stale x7", 32'h11, 1'b1, 4'd5);
      tick(); commit(5'd7, 32'h22, 4'd5);
      tick(); idle();
      @(negedge clk); lit1("final x7", 32'h22, 1'b0, 4'd0);

      tick(); rename(5'd9, 4'd4);
      tick(); commit(5'd9, 32'h55, 4'd4); rename(5'd9, 4'd6);
      tick(); idle(); id_rs1 = 5'd9;
      @(negedge clk); lit1("rn+commit x9", 32'h55, 1'b1, 4'd6);

      tick(); rename(5'd1, 4'd1);
      tick(); rename(5'd2, 4'd2);
      tick(); rename(5'd31, 4'd3);
      tick(); idle(); rob_rb_ena = 1'b1; commit(5'd1, 32'h7, 4'd1); rename(5'd4, 4'd8);
      tick(); idle(); id_rs1 = 5'd1; id_rs2 = 5'd2;
      @(negedge clk); lit1("rollback x1", 32'h7, 1'b0, 4'd0);
      chk("rollback x2 busy", 32'(id_rs2_busy), 32'd0);
      #1 id_rs1 = 5'd31; id_rs2 = 5'd4;
      @(negedge clk); lit1("rollback x31", 32'h0, 1'b0, 4'd0);
      chk("rollback x4 busy", 32'(id_rs2_busy), 32'd0);
      chk("rollback x4 tag", 32'(id_rs2_tag), 32'd0);

      tick(); rename(5'd0, 4'd5); commit(5'd0, 32'h99, 4'd0); id_rs1 = 5'd0;
      @(negedge clk); lit1("x0 same cycle", 32'h0, 1'b0, 4'd0);
      tick(); idle();
      @(negedge clk); lit1("x0 after", 32'h0, 1'b0, 4'd0);

      tick(); commit(5'd6, 32'h66, 4'd1);
      tick(); idle(); rdy = 1'b0; rename(5'd6, 4'd7); commit(5'd6, 32'h77, 4'd2);
      tick(); idle(); rdy = 1'b1; id_rs1 = 5'd6;
      @(negedge clk); lit1("rdy hold x6", 32'h66, 1'b0, 4'd0);

      for (int i = 1; i <= 12; i++) begin
         tick();
         rename(5'((i * 3) % 32), 4'((i % 15) + 1));
         commit(5'((i * 5) % 32), 32'(i * 32'h1111), 4'(((i + 7) % 15) + 1));
         id_rs1 = 5'((i * 3) % 32);
         id_rs2 = 5'((i * 5) % 32);
         rob_rb_ena = (i == 8);
      end

      tick(); idle(); commit(5'd5, 32'hAB, 4'd1);
      tick(); idle(); rename(5'd5, 4'd9);
      tick(); idle(); id_rs1 = 5'd5;
      @(negedge clk); lit1("x5 before reset", 32'hAB, 1'b1, 4'd9);
      #2 rst = 1'b0;
      #1 lit1("x5 in reset", 32'h0, 1'b0, 4'd0);
      tick(); rst = 1'b1;
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/reg_rename_file.md
Name: reg_rename_file

Overview:
- 32-entry architectural register file with per-register rename tags. Sits between ID (operand read and destination rename at issue) and ROB commit (architectural write-back).
- Each register holds a committed value, a busy flag and the ROB index of its newest in-flight producer.
- ID uses busy and tag to decide whether an operand is read from here or looked up in the ROB.
- A ROB rollback clears all renames in one cycle.

Parameters:
- ROB_BIT, 4, width of a ROB index; index 0 is reserved to mean "no producer".
- REG_NUM, 32, number of architectural registers; x0 is hardwired to zero.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- rdy  in  1  global ready; 0 freezes all state updates
- rob_rb_ena  in  1  rollback pulse from ROB; clears all busy flags and tags
- id_rs1  in  5  source register 1 index
- id_rs2  in  5  source register 2 index
- id_rs1_busy  out  1  rs1 has an uncommitted producer
- id_rs2_busy  out  1  rs2 has an uncommitted producer
- id_rs1_tag  out  ROB_BIT  producer ROB index of rs1; 0 when not busy
- id_rs2_tag  out  ROB_BIT  producer ROB index of rs2; 0 when not busy
- id_rs1_val  out  32  committed value of rs1
- id_rs2_val  out  32  committed value of rs2
- id_rn_ena  in  1  rename request for the instruction issued this cycle
- id_rn_rd  in  5  destination register to rename
- id_rn_idx  in  ROB_BIT  ROB index allocated to that instruction
- reg_wr_ena  in  1  commit write from ROB
- reg_wr_rd  in  5  commit destination register
- reg_wr_val  in  32  commit value
- reg_wr_idx  in  ROB_BIT  ROB index of the committing entry

Behaviour:
- Reset (rst=0, asynchronous): every register is set to val=0, busy=0, tag=0.
  - While rst=0, all read outputs show value 0, busy 0 and tag 0.
  - Release is synchronous to clk; the first update happens on the first posedge with rst=1.
- Reads are combinational, with no latency.
  - Index 0 always gives val=0, busy=0, tag=0.
  - Commit bypass: if reg_wr_ena=1, reg_wr_rd==rsX, rsX!=0 and tag[rsX]==reg_wr_idx, then:
    - id_rsX_val = reg_wr_val;
    - id_rsX_busy = 0;
    - id_rsX_tag = 0.
  - Same-cycle rename is not forwarded to reads. ID handles intra-cycle dependences itself.
- Sequential update on posedge clk. Priority, highest first:
  1. rst=0.
  2. rdy=0: hold all state.
  3. rob_rb_ena=1:
     - clear busy and tag on all registers;
     - a commit write in the same cycle still updates val;
     - a rename in the same cycle is discarded.
  4. Normal operation: commit, then rename.
- Commit (reg_wr_ena=1, reg_wr_rd!=0):
  - val[rd] <= reg_wr_val unconditionally.
  - If tag[rd]==reg_wr_idx: clear busy[rd] and set tag[rd] to 0.
  - Otherwise a newer producer exists; busy and tag are unchanged.
- Rename (id_rn_ena=1, id_rn_rd!=0): busy[rd] <= 1 and tag[rd] <= id_rn_idx.
- Rename and commit to the same rd in the same cycle:
  - the rename wins for busy and tag;
  - val takes the commit value.
- Writes or renames to x0 are ignored.
- id_rn_idx==0 is illegal. The block treats it as a rename with no producer (busy=1, tag=0); this condition is flagged by assertion only.
- No internal FSM beyond the per-register {busy, tag} pair. Per-register states:
  - FREE (busy=0) to RENAMED on rename;
  - RENAMED to RENAMED on re-rename (tag replaced);
  - RENAMED to FREE on matching commit or on rollback.

Test Plan:
- Reset then read: pulse rst=0 mid-run after renaming x5 -> immediately x5 reads val=0, busy=0, tag=0.
- Rename then commit:
  - rename x3 to idx 2, next cycle read x3 -> busy=1, tag=2;
  - commit x3 = 0xDEADBEEF with idx 2 -> same-cycle read gives 0xDEADBEEF, busy=0;
  - next cycle the stored value is 0xDEADBEEF and busy=0.
- Stale commit:
  - rename x7 to idx 3, then to idx 5;
  - commit x7 = 0x11 with idx 3 -> val=0x11, busy=1, tag=5;
  - commit idx 5 with 0x22 -> val=0x22, busy=0.
- Simultaneous rename and commit on x9 (tag 4): commit idx 4 with val 0x55 and rename to idx 6 in the same cycle -> val=0x55, busy=1, tag=6.
- Rollback:
  - rename x1, x2 and x31 to idx 1, 2 and 3;
  - in one cycle assert rob_rb_ena with commit x1=0x7 idx 1 and rename x4 to idx 8;
  - next cycle all four registers read busy=0, tag=0, x1 val=0x7, x4 not renamed.
- x0 and rdy:
  - rename and commit to x0 -> x0 reads 0, busy=0;
  - with rdy=0, a rename of x6 and a commit of x6 -> no state change.
